// File: rtl/sha256_msg_feeder.sv
// SHA-256 block-input feeder: buffers 32-bit message words and appends the padding
// and the 64-bit bit length. Each 512-bit block goes to the core as a 16-cycle burst.
module sha256_msg_feeder #(
  parameter int LEN_W      = 61,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        in_ready,
  input  logic        busy,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        first_block,
  output logic        last_block,
  output logic        msg_done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {FILL, PAD, GAP, WAIT, SEND, LENBLK} state_t;

  function automatic logic [31:0] keep_mask(input logic [1:0] nb);
    case (nb)
      2'd1:    keep_mask = 32'hFF00_0000;
      2'd2:    keep_mask = 32'hFFFF_0000;
      2'd3:    keep_mask = 32'hFFFF_FF00;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] pad_mark(input logic [1:0] nb);
    case (nb)
      2'd1:    pad_mark = 32'h0080_0000;
      2'd2:    pad_mark = 32'h0000_8000;
      2'd3:    pad_mark = 32'h0000_0080;
      default: pad_mark = 32'h0000_0000;
    endcase
  endfunction

  state_t             state_r, state_s;
  logic [31:0]        buf_r [16];
  logic [31:0]        buf_s [16];
  logic [3:0]         idx_r, idx_s;
  logic [LEN_W-1:0]   byte_cnt_r, byte_cnt_s;
  logic               first_r, first_s;
  logic               final_r, final_s;
  logic               extra_r, extra_s;
  logic               mark_r, mark_s;
  logic [4:0]         pad_t_r, pad_t_s;
  logic               pad_new_r, pad_new_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [3:0]         send_cnt_r, send_cnt_s;
  logic               done_s;
  logic               acc_s;
  logic [2:0]         nbytes_s;
  logic [3:0]         send_idx_s;
  logic [63:0]        len_s;

  logic               in_ready_r, write_enable_r, first_block_r, last_block_r, msg_done_r;
  logic [31:0]        data_r;
  logic               in_ready_s, write_enable_s, first_block_s, last_block_s;
  logic [31:0]        data_s;

  assign len_s = 64'({byte_cnt_r, 3'b000});

  // Next-state, buffer update and next output values.
  always_comb begin
    state_s    = state_r;
    buf_s      = buf_r;
    idx_s      = idx_r;
    byte_cnt_s = byte_cnt_r;
    first_s    = first_r;
    final_s    = final_r;
    extra_s    = extra_r;
    mark_s     = mark_r;
    pad_t_s    = pad_t_r;
    pad_new_s  = pad_new_r;
    gap_cnt_s  = gap_cnt_r;
    send_cnt_s = send_cnt_r;
    done_s     = 1'b0;
    acc_s      = in_valid && in_ready_r;
    nbytes_s   = (in_last && (in_bytes != 2'd0)) ? {1'b0, in_bytes} : 3'd4;

    case (state_r)
      FILL: begin
        if (acc_s) begin
          byte_cnt_s = byte_cnt_r + LEN_W'(nbytes_s);
          if (in_last) begin
            buf_s[idx_r] = (in_data & keep_mask(in_bytes)) | pad_mark(in_bytes);
            // A full last word pushes the 0x80 terminator into the following word.
            if (in_bytes == 2'd0) begin
              pad_t_s   = {1'b0, idx_r} + 5'd1;
              pad_new_s = 1'b1;
            end else begin
              pad_t_s   = {1'b0, idx_r};
              pad_new_s = 1'b0;
            end
            idx_s   = 4'd0;
            state_s = PAD;
          end else begin
            buf_s[idx_r] = in_data;
            if (idx_r == 4'd15) begin
              idx_s     = 4'd0;
              final_s   = 1'b0;
              extra_s   = 1'b0;
              mark_s    = 1'b0;
              gap_cnt_s = '0;
              state_s   = first_r ? WAIT : GAP;
            end else begin
              idx_s = idx_r + 4'd1;
            end
          end
        end else begin
          state_s = FILL;
        end
      end
      PAD: begin
        for (int j = 0; j < 16; j++) begin
          if (pad_new_r && (5'(j) == pad_t_r)) begin
            buf_s[j] = 32'h8000_0000;
          end else if (5'(j) > pad_t_r) begin
            buf_s[j] = 32'h0000_0000;
          end else begin
            buf_s[j] = buf_r[j];
          end
        end
        if (pad_t_r <= 5'd13) begin
          buf_s[14] = len_s[63:32];
          buf_s[15] = len_s[31:0];
          final_s   = 1'b1;
          extra_s   = 1'b0;
          mark_s    = 1'b0;
        end else begin
          final_s   = 1'b0;
          extra_s   = 1'b1;
          mark_s    = (pad_t_r == 5'd16);
        end
        gap_cnt_s = '0;
        state_s   = first_r ? WAIT : GAP;
      end
      GAP: begin
        if (int'(gap_cnt_r) + 32'sd1 >= GAP_CYCLES) begin
          state_s = WAIT;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      WAIT: begin
        if (!busy) begin
          send_cnt_s = 4'd0;
          state_s    = SEND;
        end else begin
          state_s = WAIT;
        end
      end
      SEND: begin
        if (send_cnt_r == 4'd15) begin
          first_s = 1'b0;
          idx_s   = 4'd0;
          if (final_r) begin
            done_s     = 1'b1;
            byte_cnt_s = '0;
            first_s    = 1'b1;
            state_s    = FILL;
          end else if (extra_r) begin
            state_s = LENBLK;
          end else begin
            state_s = FILL;
          end
        end else begin
          send_cnt_s = send_cnt_r + 4'd1;
        end
      end
      LENBLK: begin
        for (int j = 0; j < 16; j++) begin
          buf_s[j] = 32'h0000_0000;
        end
        buf_s[0]  = mark_r ? 32'h8000_0000 : 32'h0000_0000;
        buf_s[14] = len_s[63:32];
        buf_s[15] = len_s[31:0];
        final_s   = 1'b1;
        extra_s   = 1'b0;
        mark_s    = 1'b0;
        gap_cnt_s = '0;
        state_s   = GAP;
      end
      default: begin
        state_s = FILL;
      end
    endcase

    // Outputs are registered against the state being entered, so they line up with it.
    send_idx_s     = (state_r == SEND) ? (send_cnt_r + 4'd1) : 4'd0;
    write_enable_s = (state_s == SEND);
    data_s         = write_enable_s ? buf_r[send_idx_s] : 32'h0000_0000;
    first_block_s  = (state_r == WAIT) && (state_s == SEND) && first_r;
    last_block_s   = (state_r == WAIT) && (state_s == SEND) && final_r;
    in_ready_s     = (state_s == FILL) && !done_s;
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= FILL;
      for (int j = 0; j < 16; j++) begin
        buf_r[j] <= 32'h0000_0000;
      end
      idx_r          <= 4'd0;
      byte_cnt_r     <= '0;
      first_r        <= 1'b1;
      final_r        <= 1'b0;
      extra_r        <= 1'b0;
      mark_r         <= 1'b0;
      pad_t_r        <= 5'd0;
      pad_new_r      <= 1'b0;
      gap_cnt_r      <= '0;
      send_cnt_r     <= 4'd0;
      in_ready_r     <= 1'b0;
      data_r         <= 32'h0000_0000;
      write_enable_r <= 1'b0;
      first_block_r  <= 1'b0;
      last_block_r   <= 1'b0;
      msg_done_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      buf_r          <= buf_s;
      idx_r          <= idx_s;
      byte_cnt_r     <= byte_cnt_s;
      first_r        <= first_s;
      final_r        <= final_s;
      extra_r        <= extra_s;
      mark_r         <= mark_s;
      pad_t_r        <= pad_t_s;
      pad_new_r      <= pad_new_s;
      gap_cnt_r      <= gap_cnt_s;
      send_cnt_r     <= send_cnt_s;
      in_ready_r     <= in_ready_s;
      data_r         <= data_s;
      write_enable_r <= write_enable_s;
      first_block_r  <= first_block_s;
      last_block_r   <= last_block_s;
      msg_done_r     <= done_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign data         = data_r;
  assign write_enable = write_enable_r;
  assign first_block  = first_block_r;
  assign last_block   = last_block_r;
  assign msg_done     = msg_done_r;

endmodule
